axi_lite_slave_regs: RTL and testbench

AXI4-Lite responder that exposes a bank of `NUM_REGS` read/write registers to a bus master. It is the subordinate-side counterpart of the team's AXI-Lite master and sits between the interconnect and a peripheral's control/status logic. It decodes word addresses, applies byte strobes, and issues OKAY or error responses.

---
 rtl/axi_lite_slave_regs_if.sv | 38 +++
 rtl/axi_lite_slave_regs.sv | 168 ++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite write/read channel bundle between a bus master and the
// register-bank responder.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS read/write registers.
// Define AXI_LITE_SLAVE_DECERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi_lite_slave_regs_if.slave           bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_DECERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    typedef enum logic [2:0] {
        W_IDLE, W_ADDR, W_DATA, W_COMMIT, W_RESP
    } w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic aw_held, w_held, bvalid, rvalid;
    logic awready, wready, arready;
    logic aw_hs, w_hs, ar_hs, commit;
    logic wr_ok, rd_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx = addr[ADDR_LSB +: IDX_W];
        return (32'(idx) < NUM_REGS) &&
               ((addr >> (ADDR_LSB + IDX_W)) == '0);
    endfunction

    // Ready/valid derive only from FSM state, never from incoming valids.
    assign aw_held = (w_state == W_ADDR) || (w_state == W_COMMIT);
    assign w_held  = (w_state == W_DATA) || (w_state == W_COMMIT);
    assign bvalid  = (w_state == W_RESP);
    assign awready = !aw_held && !bvalid;
    assign wready  = !w_held && !bvalid;
    assign rvalid  = (r_state == R_RESP);
    assign arready = !rvalid;

    assign aw_hs  = bus.awvalid && awready;
    assign w_hs   = bus.wvalid && wready;
    assign ar_hs  = bus.arvalid && arready;
    assign commit = (w_state == W_COMMIT);

    assign wr_idx = aw_addr[ADDR_LSB +: IDX_W];
    assign wr_ok  = in_range(aw_addr);
    assign rd_idx = bus.araddr[ADDR_LSB +: IDX_W];
    assign rd_ok  = in_range(bus.araddr);

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_ADDR;
                else if (w_hs)     w_next = W_DATA;
            end
            W_ADDR:   if (w_hs)       w_next = W_COMMIT;
            W_DATA:   if (aw_hs)      w_next = W_COMMIT;
            W_COMMIT:                 w_next = W_RESP;
            W_RESP:   if (bus.bready) w_next = W_IDLE;
            default:                  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs)      r_next = R_RESP;
            R_RESP: if (bus.rready) r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) aw_addr <= bus.awaddr;
            if (w_hs) begin
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
        end
    end

    // A zero strobe still counts as a write and pulses its register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
            bresp_q      <= OKAY;
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                bresp_q <= wr_ok ? OKAY : ERR_RESP;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_ok && wr_idx == IDX_W'(i)) begin
                        reg_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb[b])
                                regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Capture samples the pre-commit value when colliding with a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_ok ? regs[rd_idx] : '0;
            rresp_q <= rd_ok ? OKAY : ERR_RESP;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: write/read ordering, strobes,
// collisions, out-of-range decode and asynchronous reset.
module tb_axi_lite_slave_regs;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
`ifdef AXI_LITE_SLAVE_DECERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*DW-1:0] regs_out;
    logic [NR-1:0] reg_wr_pulse;
    int passed = 0;
    int total = 0;
    logic [1:0] resp;
    logic [7:0] pulse;
    logic [31:0] data;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    axi_lite_slave_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif),
        .regs_out(regs_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_of(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] r,
                      output logic [7:0] p);
        @(negedge clk);
        bif.awaddr = a; bif.awvalid = 1'b1;
        bif.wdata = d; bif.wstrb = s; bif.wvalid = 1'b1;
        @(negedge clk);
        bif.awvalid = 1'b0; bif.wvalid = 1'b0; bif.bready = 1'b1;
        @(negedge clk);
        r = bif.bresp; p = reg_wr_pulse;
        @(negedge clk);
        bif.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        @(negedge clk);
        bif.araddr = a; bif.arvalid = 1'b1; bif.rready = 1'b0;
        @(negedge clk);
        d = bif.rdata; r = bif.rresp;
        bif.arvalid = 1'b0; bif.rready = 1'b1;
        @(negedge clk);
        bif.rready = 1'b0;
    endtask

    initial begin
        bif.awaddr = '0; bif.awvalid = 1'b0;
        bif.wdata = '0; bif.wstrb = '0; bif.wvalid = 1'b0;
        bif.bready = 1'b0;
        bif.araddr = '0; bif.arvalid = 1'b0; bif.rready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_readys", 32'({bif.awready, bif.wready, bif.arready}), 7);
        chk("rst_valids", 32'({bif.bvalid, bif.rvalid}), 0);
        chk("rst_resps", 32'({bif.bresp, bif.rresp}), 0);
        chk("rst_rdata", bif.rdata, 0);
        chk("rst_regs", 32'(regs_out === '0), 1);
        chk("rst_pulse", 32'(reg_wr_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // same-cycle AW+W to reg1
        @(negedge clk);
        bif.awaddr = 32'h04; bif.awvalid = 1'b1;
        bif.wdata = 32'hDEADBEEF; bif.wstrb = 4'hF; bif.wvalid = 1'b1;
        @(posedge clk); #1;
        chk("t1_bvalid_k", 32'(bif.bvalid), 0);
        chk("t1_awready_busy", 32'(bif.awready), 0);
        @(negedge clk);
        bif.awvalid = 1'b0; bif.wvalid = 1'b0;
        @(posedge clk); #1;
        chk("t1_bvalid", 32'(bif.bvalid), 1);
        chk("t1_bresp", 32'(bif.bresp), 0);
        chk("t1_reg1", reg_of(1), 32'hDEADBEEF);
        chk("t1_pulse", 32'(reg_wr_pulse), 32'h02);
        @(posedge clk); #1;
        chk("t1_pulse_end", 32'(reg_wr_pulse), 0);
        chk("t1_bvalid_hold", 32'(bif.bvalid), 1);
        @(negedge clk);
        bif.bready = 1'b1;
        @(posedge clk); #1;
        chk("t1_b_done", 32'({bif.bvalid, bif.awready, bif.wready}), 3);
        @(negedge clk);
        bif.bready = 1'b0;

        // W first, AW three cycles later, partial strobe
        wr(32'h08, 32'hAABBCCDD, 4'hF, resp, pulse);
        chk("t2_prior", reg_of(2), 32'hAABBCCDD);
        @(negedge clk);
        bif.wdata = 32'h11223344; bif.wstrb = 4'h5; bif.wvalid = 1'b1;
        @(posedge clk); #1;
        chk("t2_w_held", 32'({bif.wready, bif.awready}), 1);
        @(negedge clk);
        bif.wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bif.awaddr = 32'h08; bif.awvalid = 1'b1;
        @(posedge clk); #1;
        chk("t2_bvalid_k", 32'(bif.bvalid), 0);
        @(negedge clk);
        bif.awvalid = 1'b0; bif.bready = 1'b1;
        @(posedge clk); #1;
        chk("t2_bvalid", 32'(bif.bvalid), 1);
        chk("t2_reg2", reg_of(2), 32'hAA22CC44);
        chk("t2_pulse", 32'(reg_wr_pulse), 32'h04);
        @(posedge clk); #1;
        chk("t2_b_done", 32'(bif.bvalid), 0);
        @(negedge clk);
        bif.bready = 1'b0;

        // read with rready held low
        @(negedge clk);
        bif.araddr = 32'h04; bif.arvalid = 1'b1; bif.rready = 1'b0;
        @(posedge clk); #1;
        chk("t3_rvalid", 32'(bif.rvalid), 1);
        chk("t3_rdata", bif.rdata, 32'hDEADBEEF);
        chk("t3_rresp", 32'(bif.rresp), 0);
        @(negedge clk);
        bif.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t3_stall", 32'({bif.rvalid, bif.arready}), 2);
            chk("t3_stall_data", bif.rdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        bif.rready = 1'b1;
        @(posedge clk); #1;
        chk("t3_r_done", 32'({bif.rvalid, bif.arready}), 1);
        @(negedge clk);
        bif.rready = 1'b0;

        // read captured on the commit edge sees the old value
        @(negedge clk);
        bif.awaddr = 32'h00; bif.awvalid = 1'b1;
        bif.wdata = 32'h55; bif.wstrb = 4'hF; bif.wvalid = 1'b1;
        @(negedge clk);
        bif.awvalid = 1'b0; bif.wvalid = 1'b0;
        bif.araddr = 32'h00; bif.arvalid = 1'b1;
        @(posedge clk); #1;
        chk("t4_valids", 32'({bif.bvalid, bif.rvalid}), 3);
        chk("t4_old", bif.rdata, 0);
        chk("t4_reg0", reg_of(0), 32'h55);
        @(negedge clk);
        bif.arvalid = 1'b0; bif.rready = 1'b1; bif.bready = 1'b1;
        @(posedge clk); #1;
        chk("t4_done", 32'({bif.bvalid, bif.rvalid}), 0);
        @(negedge clk);
        bif.rready = 1'b0; bif.bready = 1'b0;
        rd(32'h00, data, resp);
        chk("t4_new", data, 32'h55);

        // zero strobe: pulse and OKAY but no data change
        wr(32'h0C, 32'hFFFFFFFF, 4'h0, resp, pulse);
        chk("t5_bresp", 32'(resp), 0);
        chk("t5_pulse", 32'(pulse), 32'h08);
        chk("t5_reg3", reg_of(3), 0);

        // out of range
        wr(32'h40, 32'hFFFFFFFF, 4'hF, resp, pulse);
        chk("t6_bresp", 32'(resp), 32'(EXP_ERR));
        chk("t6_pulse", 32'(pulse), 0);
        chk("t6_reg0", reg_of(0), 32'h55);
        chk("t6_reg1", reg_of(1), 32'hDEADBEEF);
        rd(32'h40, data, resp);
        chk("t6_rdata", data, 0);
        chk("t6_rresp", 32'(resp), 32'(EXP_ERR));
        rd(32'h20, data, resp);
        chk("t6_rdata20", data, 0);
        chk("t6_rresp20", 32'(resp), 32'(EXP_ERR));
        rd(32'h07, data, resp);
        chk("t6_lowbits", data, 32'hDEADBEEF);
        chk("t6_lowresp", 32'(resp), 0);

        // AW first, last register, then reset with bvalid pending
        @(negedge clk);
        bif.awaddr = 32'h1C; bif.awvalid = 1'b1;
        @(posedge clk); #1;
        chk("t7_aw_held", 32'({bif.awready, bif.wready}), 1);
        @(negedge clk);
        bif.awvalid = 1'b0;
        bif.wdata = 32'h12345678; bif.wstrb = 4'hF; bif.wvalid = 1'b1;
        @(negedge clk);
        bif.wvalid = 1'b0;
        @(posedge clk); #1;
        chk("t7_bvalid", 32'(bif.bvalid), 1);
        chk("t7_reg7", reg_of(7), 32'h12345678);
        chk("t7_pulse", 32'(reg_wr_pulse), 32'h80);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t8_bvalid", 32'(bif.bvalid), 0);
        chk("t8_regs", 32'(regs_out === '0), 1);
        chk("t8_readys", 32'({bif.awready, bif.wready, bif.arready}), 7);
        chk("t8_pulse", 32'(reg_wr_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h1C, data, resp);
        chk("t8_reg7_read", data, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
